cpu_controller: RTL and testbench

Multi-cycle sequencer for the simple CPU: fetches 12-bit instructions from a combinational instruction memory, drives the 8×4-bit `register_file` read/write ports, executes through a 4-bit ALU, and writes results back. It is the only master of the register file in the core; testbenches and the top level instantiate it beside `register_file` and the instruction ROM.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cpu_controller_alu.sv | 22 ++
 rtl/cpu_controller.sv | 108 ++++++++++
 tb/tb_cpu_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, FSM states, widths and instruction field slices for the CPU sequencer
package cpu_pkg;
  localparam int INSTR_W = 12;
  localparam int REG_ADDR_W = 3;
  localparam int DATA_W = 4;
  localparam int OP_HI = 11;
  localparam int OP_LO = 9;
  localparam int RD_HI = 8;
  localparam int RD_LO = 6;
  localparam int RA_HI = 5;
  localparam int RA_LO = 3;
  localparam int RB_HI = 2;
  localparam int RB_LO = 0;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;
  typedef enum logic [2:0] {
    OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_HALT, OP_RSVD
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALTED
  } state_e;
  function automatic logic op_writes(op_e op);
    return op >= OP_LDI && op <= OP_OR;
  endfunction
endpackage

// File: rtl/cpu_controller_alu.sv
// alu: 4-bit combinational ALU; ports op_i/a_i/b_i in, result_o and carry_o (carry for ADD, borrow for SUB) out
module alu
  import cpu_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);
  logic [DATA_W:0] sum, diff;
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    diff = {1'b0, a_i} - {1'b0, b_i};
    result_o = op_i == OP_ADD ? sum[DATA_W-1:0] :
               op_i == OP_SUB ? diff[DATA_W-1:0] :
               op_i == OP_AND ? a_i & b_i :
               op_i == OP_OR  ? a_i | b_i :
               op_i == OP_LDI ? b_i : '0;
    carry_o = op_i == OP_SUB ? diff[DATA_W] : sum[DATA_W];
  end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle FETCH/DECODE/EXECUTE sequencer; drives imem address, register-file ports, flags, busy/halted and retire count
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [PC_WIDTH-1:0]   imem_address,
  input  logic [INSTR_W-1:0]    imem_data,
  output logic [REG_ADDR_W-1:0] read_address1,
  output logic [REG_ADDR_W-1:0] read_address2,
  input  logic [DATA_W-1:0]     read_data1,
  input  logic [DATA_W-1:0]     read_data2,
  output logic [REG_ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0]     write_data,
  output logic                  write_enable,
  output logic                  busy,
  output logic                  halted,
  output logic                  zero,
  output logic                  carry,
  output logic [7:0]            retire_count
);
  state_e state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_b, alu_res;
  logic zero_q, zero_d, carry_q, carry_d, alu_carry, exec;
  logic [7:0] retire_q, retire_d;
  op_e op;
  assign op = op_e'(ir_q[OP_HI:OP_LO]);
  // LDI's immediate overlaps the rb/ra fields, so it bypasses the latched operand
  assign alu_b = op == OP_LDI ? ir_q[IMM_HI:IMM_LO] : b_q;
  alu u_alu (
    .op_i(ir_q[OP_HI:OP_LO]),
    .a_i(a_q),
    .b_i(alu_b),
    .result_o(alu_res),
    .carry_o(alu_carry)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      zero_q <= zero_d;
      carry_q <= carry_d;
      retire_q <= retire_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    zero_d = zero_q;
    carry_d = carry_q;
    retire_d = retire_q;
    case (state_q)
      S_IDLE, S_HALTED: if (start) begin
        state_d = S_FETCH;
        pc_d = '0;
      end
      S_FETCH: begin
        ir_d = imem_data;
        pc_d = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = read_data1;
        b_d = read_data2;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        retire_d = retire_q + 8'd1;
        state_d = op == OP_HALT ? S_HALTED : S_FETCH;
        zero_d = op_writes(op) ? alu_res == '0 : zero_q;
        carry_d = op == OP_ADD || op == OP_SUB ? alu_carry : carry_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign exec = state_q == S_EXECUTE;
  assign imem_address = pc_q;
  assign read_address1 = ir_q[RA_HI:RA_LO];
  assign read_address2 = ir_q[RB_HI:RB_LO];
  assign write_address = ir_q[RD_HI:RD_LO];
  assign write_enable = exec && op_writes(op);
  assign write_data = write_enable ? alu_res : '0;
  assign busy = state_q == S_FETCH || state_q == S_DECODE || exec;
  assign halted = state_q == S_HALTED;
  assign zero = zero_q;
  assign carry = carry_q;
  assign retire_count = retire_q;
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed programs against cpu_controller with a behavioural register file and instruction ROM
module tb_cpu_controller;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0;
  logic [3:0] imem_address;
  logic [11:0] imem_data;
  logic [2:0] ra1, ra2, wa;
  logic [3:0] rd1, rd2, wd;
  logic we, busy, halted, zero, carry;
  logic [7:0] retire;
  logic [1:0] imem_address2;
  logic [2:0] ra1_2, ra2_2, wa_2;
  logic [3:0] wd_2;
  logic we_2, busy_2, halted_2, zero_2, carry_2;
  logic [7:0] retire_2;
  logic [11:0] imem [16];
  logic [3:0] rf [8];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_address(imem_address), .imem_data(imem_data),
    .read_address1(ra1), .read_address2(ra2),
    .read_data1(rd1), .read_data2(rd2),
    .write_address(wa), .write_data(wd), .write_enable(we),
    .busy(busy), .halted(halted), .zero(zero), .carry(carry),
    .retire_count(retire)
  );

  cpu_controller #(.PC_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .imem_address(imem_address2), .imem_data(12'h000),
    .read_address1(ra1_2), .read_address2(ra2_2),
    .read_data1(4'h0), .read_data2(4'h0),
    .write_address(wa_2), .write_data(wd_2), .write_enable(we_2),
    .busy(busy_2), .halted(halted_2), .zero(zero_2), .carry(carry_2),
    .retire_count(retire_2)
  );

  assign imem_data = imem[imem_address];
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  always @(posedge clk) if (we) rf[wa] <= wd;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [11:0] ins(input logic [2:0] op, rd, ra, rb);
    return {op, rd, ra, rb};
  endfunction

  function automatic logic [11:0] ldi(input logic [2:0] rd, input logic [3:0] imm);
    return {3'b001, rd, 2'b00, imm};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 12'h000;
    for (int i = 0; i < 8; i++) rf[i] = 4'h0;
    imem[0] = ldi(3'd1, 4'd5);
    imem[1] = ldi(3'd2, 4'd3);
    imem[2] = ins(3'b010, 3'd3, 3'd1, 3'd2);
    imem[3] = ins(3'b110, 3'd0, 3'd0, 3'd0);
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_we", we, 0);
    check("rst_addr", imem_address, 0);
    check("rst_retire", retire, 0);
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p1_fetch_busy", busy, 1);
    check("p1_fetch_addr", imem_address, 0);
    tick(2);
    check("p1_ldi_we", we, 1);
    check("p1_ldi_wa", wa, 1);
    check("p1_ldi_wd", wd, 5);
    tick(10);
    check("p1_halted", halted, 1);
    check("p1_busy", busy, 0);
    check("p1_retire", retire, 4);
    check("p1_r3", rf[3], 8);
    check("p1_zero", zero, 0);
    check("p1_carry", carry, 0);
    imem[0] = ins(3'b011, 3'd4, 3'd2, 3'd1);
    imem[1] = ins(3'b011, 3'd5, 3'd1, 3'd1);
    imem[2] = ldi(3'd6, 4'd15);
    imem[3] = ldi(3'd7, 4'd1);
    imem[4] = ins(3'b010, 3'd0, 3'd6, 3'd7);
    imem[5] = ldi(3'd6, 4'd12);
    imem[6] = ldi(3'd7, 4'd10);
    imem[7] = ins(3'b100, 3'd0, 3'd6, 3'd7);
    imem[8] = ins(3'b101, 3'd1, 3'd6, 3'd7);
    imem[9] = ins(3'b110, 3'd0, 3'd0, 3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p2_restart_halted", halted, 0);
    check("p2_restart_addr", imem_address, 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_addr", imem_address, 1);
    check("busy_start_busy", busy, 1);
    check("sub_we", we, 1);
    check("sub_wd", wd, 14);
    tick();
    check("sub_carry", carry, 1);
    check("sub_zero", zero, 0);
    check("sub_retire", retire, 5);
    check("sub_r4", rf[4], 14);
    tick(3);
    check("subz_zero", zero, 1);
    check("subz_carry", carry, 0);
    check("subz_r5", rf[5], 0);
    tick(9);
    check("add_wrap_r0", rf[0], 0);
    check("add_wrap_carry", carry, 1);
    check("add_wrap_zero", zero, 1);
    tick(9);
    check("and_r0", rf[0], 8);
    check("and_carry", carry, 1);
    check("and_zero", zero, 0);
    tick(3);
    check("or_r1", rf[1], 14);
    tick(3);
    check("p2_halted", halted, 1);
    check("p2_retire", retire, 14);
    imem[0] = ldi(3'd6, 4'd9);
    imem[1] = ins(3'b110, 3'd0, 3'd0, 3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    check("p3_we_pre", we, 1);
    check("p3_wd_pre", wd, 9);
    check("p3_wa_pre", wa, 6);
    reset = 1'b1;
    #1;
    check("arst_we", we, 0);
    check("arst_wd", wd, 0);
    check("arst_wa", wa, 0);
    check("arst_busy", busy, 0);
    check("arst_halted", halted, 0);
    check("arst_zero", zero, 0);
    check("arst_carry", carry, 0);
    check("arst_retire", retire, 0);
    check("arst_addr", imem_address, 0);
    check("arst_ra1", ra1, 0);
    tick();
    reset = 1'b0;
    tick();
    check("arst_r6_kept", rf[6], 12);
    check("arst_idle_busy", busy, 0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("pc2_addr0", imem_address2, 0);
    check("pc2_busy", busy_2, 1);
    for (int k = 1; k <= 4; k++) begin
      tick(3);
      check($sformatf("pc2_addr%0d", k), imem_address2, k % 4);
      check($sformatf("pc2_retire%0d", k), retire_2, k);
    end
    check("pc2_not_halted", halted_2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
